nubus_slave: RTL and testbench

NuBus slave bus-interface unit: decodes NuBus start cycles addressed to this card's slot or super-slot space and converts each single-beat transaction into a valid/ready request on a local memory port. It returns read data and completion status to the bus master with a one-clock acknowledge. It sits between the NuBus backplane pins and the card's local memory or register decoder.

---
 rtl/nubus_pkg.sv | 41 ++++
 rtl/nubus_slave_decode.sv | 25 ++
 rtl/nubus_slave.sv | 157 +++++++++++++++
 tb/tb_nubus_slave.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nubus_pkg.sv
// Shared types for the NuBus slave: transfer sizes, ack status codes,
// FSM states and the byte-strobe helper.
package nubus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WDATA = 2'd1,
      ST_MEM   = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      STAT_COMPLETE = 2'b00,
      STAT_ERROR    = 2'b01,
      STAT_TIMEOUT  = 2'b10,
      STAT_RETRY    = 2'b11
   } status_t;

   // {A1,A0} meaning when TM0=0
   localparam logic [1:0] SZ_WORD  = 2'b00;
   localparam logic [1:0] SZ_BLOCK = 2'b01;
   localparam logic [1:0] SZ_HALF0 = 2'b10;
   localparam logic [1:0] SZ_HALF1 = 2'b11;

   function automatic logic [3:0] byte_strobe(input logic tm0, input logic [1:0] a10);
      logic [3:0] strb;
      strb = 4'b0000;
      if (tm0) begin
         strb = 4'b0001 << a10;
      end else begin
         case (a10)
            SZ_WORD:  strb = 4'b1111;
            SZ_HALF0: strb = 4'b0011;
            SZ_HALF1: strb = 4'b1100;
            default:  strb = 4'b0000;
         endcase
      end
      return strb;
   endfunction

endpackage

// File: rtl/nubus_slave_decode.sv
// Start-cycle decode: slot / super-slot match and transfer-mode to strobe/type.
module nubus_slave_decode
   import nubus_pkg::*;
#(
   parameter bit SUPER_ENABLE = 1'b1
) (
   input  logic [31:0] addr,
   input  logic [3:0]  slot_id,
   input  logic        tm1,
   input  logic        tm0,
   output logic        myslot,
   output logic        super_hit,
   output logic        is_write,
   output logic        is_block,
   output logic [3:0]  strobe
);

   assign myslot    = (addr[31:24] == {4'hF, slot_id});
   // Slot 0 has no super-slot space, so it never claims 0xxxxxxx.
   assign super_hit = SUPER_ENABLE && (slot_id != 4'h0) && (addr[31:28] == slot_id);
   assign is_write  = tm1;
   assign is_block  = !tm0 && (addr[1:0] == SZ_BLOCK);
   assign strobe    = byte_strobe(tm0, addr[1:0]);

endmodule

// File: rtl/nubus_slave.sv
// NuBus single-beat slave: converts matching start cycles into valid/ready
// requests on the local memory port and returns a one-clock acknowledge.
module nubus_slave
   import nubus_pkg::*;
#(
   parameter bit SUPER_ENABLE = 1'b1
) (
   input  logic        nub_clkn,
   input  logic        nub_resetn,
   input  logic [3:0]  nub_idn,
   input  logic        nub_startn,
   inout  tri logic [31:0] nub_adn,
   inout  tri logic    nub_tm1n,
   inout  tri logic    nub_tm0n,
   inout  tri logic    nub_ackn,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [3:0]  mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        mem_myslot,
   output logic        mem_super
);

   state_t      state_reg, state_next;
   logic        mem_valid_next, mem_myslot_next, mem_super_next;
   logic [3:0]  mem_write_next;
   logic [31:0] mem_addr_next, mem_wdata_next;
   logic        wr_reg, wr_next, blk_reg, blk_next;
   logic [3:0]  strobe_reg, strobe_next;
   logic [31:0] rdata_reg, rdata_next;

   logic        ack_oe_reg, data_oe_reg;
   logic [31:0] adn_out_reg;
   status_t     status_reg;

   logic [31:0] a_in;
   logic        dec_myslot, dec_super, dec_write, dec_block;
   logic [3:0]  dec_strobe;

   assign a_in = ~nub_adn;

   nubus_slave_decode #(.SUPER_ENABLE(SUPER_ENABLE)) u_decode (
      .addr      (a_in),
      .slot_id   (~nub_idn),
      .tm1       (~nub_tm1n),
      .tm0       (~nub_tm0n),
      .myslot    (dec_myslot),
      .super_hit (dec_super),
      .is_write  (dec_write),
      .is_block  (dec_block),
      .strobe    (dec_strobe)
   );

   always_comb begin
      state_next      = state_reg;
      mem_valid_next  = mem_valid;
      mem_write_next  = mem_write;
      mem_addr_next   = mem_addr;
      mem_wdata_next  = mem_wdata;
      mem_myslot_next = mem_myslot;
      mem_super_next  = mem_super;
      wr_next         = wr_reg;
      blk_next        = blk_reg;
      strobe_next     = strobe_reg;
      rdata_next      = rdata_reg;
      case (state_reg)
         ST_IDLE: begin
            if (!nub_startn && (dec_myslot || dec_super)) begin
               mem_addr_next   = {a_in[31:2], 2'b00};
               mem_myslot_next = dec_myslot;
               mem_super_next  = dec_super;
               wr_next         = dec_write;
               blk_next        = dec_block;
               strobe_next     = dec_strobe;
               if (dec_block) begin
                  state_next = ST_ACK;
               end else if (dec_write) begin
                  state_next = ST_WDATA;
               end else begin
                  mem_valid_next = 1'b1;
                  state_next     = ST_MEM;
               end
            end
         end
         ST_WDATA: begin
            mem_wdata_next = a_in;
            mem_write_next = strobe_reg;
            mem_valid_next = 1'b1;
            state_next     = ST_MEM;
         end
         ST_MEM: begin
            if (mem_ready) begin
               rdata_next     = mem_rdata;
               mem_valid_next = 1'b0;
               mem_write_next = 4'b0000;
               state_next     = ST_ACK;
            end
         end
         ST_ACK: begin
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Core state samples on the falling edge, matching NuBus sample timing.
   always_ff @(negedge nub_clkn or negedge nub_resetn) begin
      if (!nub_resetn) begin
         state_reg  <= ST_IDLE;
         mem_valid  <= 1'b0;
         mem_write  <= 4'b0000;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_myslot <= 1'b0;
         mem_super  <= 1'b0;
         wr_reg     <= 1'b0;
         blk_reg    <= 1'b0;
         strobe_reg <= 4'b0000;
         rdata_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         mem_valid  <= mem_valid_next;
         mem_write  <= mem_write_next;
         mem_addr   <= mem_addr_next;
         mem_wdata  <= mem_wdata_next;
         mem_myslot <= mem_myslot_next;
         mem_super  <= mem_super_next;
         wr_reg     <= wr_next;
         blk_reg    <= blk_next;
         strobe_reg <= strobe_next;
         rdata_reg  <= rdata_next;
      end
   end

   // Bus drivers re-registered on the rising edge so pins only move there.
   always_ff @(posedge nub_clkn or negedge nub_resetn) begin
      if (!nub_resetn) begin
         ack_oe_reg  <= 1'b0;
         data_oe_reg <= 1'b0;
         adn_out_reg <= '0;
         status_reg  <= STAT_COMPLETE;
      end else begin
         ack_oe_reg  <= (state_reg == ST_ACK);
         data_oe_reg <= (state_reg == ST_ACK) && !wr_reg && !blk_reg;
         adn_out_reg <= ~rdata_reg;
         status_reg  <= blk_reg ? STAT_ERROR : STAT_COMPLETE;
      end
   end

   assign nub_ackn = ack_oe_reg  ? 1'b0           : 1'bz;
   assign nub_tm1n = ack_oe_reg  ? ~status_reg[1] : 1'bz;
   assign nub_tm0n = ack_oe_reg  ? ~status_reg[0] : 1'bz;
   assign nub_adn  = data_oe_reg ? adn_out_reg    : 32'bz;

endmodule

// File: tb/tb_nubus_slave.sv
// Bench for nubus_slave: NuBus master driver, wait-state memory model and a
// word-level reference memory for expected read data.
module tb_nubus_slave;

   logic        nub_clkn = 1'b0;
   logic        nub_resetn = 1'b0;
   logic [3:0]  nub_idn = 4'hF;
   logic        nub_startn = 1'b1;
   tri1  [31:0] nub_adn;
   tri1         nub_tm1n, nub_tm0n, nub_ackn;

   logic        mem_valid, mem_ready;
   logic [3:0]  mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_myslot, mem_super;

   logic [31:0] m_adn = '0;
   logic        m_adn_oe = 1'b0;
   logic        m_tm1n = 1'b1, m_tm0n = 1'b1, m_tm_oe = 1'b0;

   assign nub_adn  = m_adn_oe ? m_adn  : 32'bz;
   assign nub_tm1n = m_tm_oe  ? m_tm1n : 1'bz;
   assign nub_tm0n = m_tm_oe  ? m_tm0n : 1'bz;

   always #50 nub_clkn = ~nub_clkn;

   nubus_slave #(.SUPER_ENABLE(1'b1)) dut (
      .nub_clkn   (nub_clkn),
      .nub_resetn (nub_resetn),
      .nub_idn    (nub_idn),
      .nub_startn (nub_startn),
      .nub_adn    (nub_adn),
      .nub_tm1n   (nub_tm1n),
      .nub_tm0n   (nub_tm0n),
      .nub_ackn   (nub_ackn),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_myslot (mem_myslot),
      .mem_super  (mem_super)
   );

   // nubus_memory: zero-initialised, clocked on ~nub_clkn, mem_wait clocks before ready
   wire         mem_clk = ~nub_clkn;
   logic [31:0] mem_store [256];
   int          mem_wait = 0;
   int          wait_cnt = 0;

   assign mem_ready = mem_valid && (wait_cnt >= mem_wait);
   assign mem_rdata = mem_store[mem_addr[9:2]];

   always @(posedge mem_clk) begin
      if (!mem_valid) begin
         wait_cnt <= 0;
      end else if (!mem_ready) begin
         wait_cnt <= wait_cnt + 1;
      end else begin
         wait_cnt <= 0;
         for (int b = 0; b < 4; b++)
            if (mem_write[b]) mem_store[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
   end

   // Bus monitor, sampled on falling edges (outputs move on rising edges).
   int          cyc = 0;
   int          ready_cyc, ack_first, ack_count;
   bit          valid_seen, valid_in_ack;
   logic [3:0]  strobe_seen;
   logic [31:0] addr_seen, wdata_seen, rdata_seen;
   logic        myslot_seen, super_seen;
   logic [1:0]  stat_seen;

   always @(negedge nub_clkn) begin
      cyc = cyc + 1;
      if (mem_valid) begin
         valid_seen  = 1'b1;
         strobe_seen = mem_write;
         addr_seen   = mem_addr;
         wdata_seen  = mem_wdata;
         myslot_seen = mem_myslot;
         super_seen  = mem_super;
         if (mem_ready) ready_cyc = cyc;
      end
      if (nub_ackn === 1'b0) begin
         if (ack_count == 0) ack_first = cyc;
         ack_count  = ack_count + 1;
         stat_seen  = {~nub_tm1n, ~nub_tm0n};
         rdata_seen = ~nub_adn;
         if (mem_valid) valid_in_ack = 1'b1;
      end
   end

   // Reference model: word-addressed image, bytes merged under the spec's lane rules.
   logic [31:0] ref_mem [256];
   logic [3:0]  size_tbl [4] = '{4'b1111, 4'b0000, 4'b0011, 4'b1100};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic clear_mon();
      valid_seen = 1'b0; valid_in_ack = 1'b0; ack_count = 0;
      ready_cyc = -100; ack_first = -100; strobe_seen = 4'hx;
   endtask

   task automatic bus_start(input logic [31:0] addr, input logic wr, input logic tm0,
                            input logic [31:0] data);
      @(posedge nub_clkn);
      nub_startn = 1'b0; m_adn = ~addr; m_adn_oe = 1'b1;
      m_tm1n = ~wr; m_tm0n = ~tm0; m_tm_oe = 1'b1;
      @(posedge nub_clkn);
      nub_startn = 1'b1; m_tm_oe = 1'b0;
      if (wr) m_adn = ~data;
      else m_adn_oe = 1'b0;
      @(posedge nub_clkn);
      m_adn_oe = 1'b0;
   endtask

   task automatic do_txn(input logic [31:0] addr, input logic wr, input logic tm0,
                         input logic [31:0] data, input int wclk, input bit hit,
                         input bit exp_my, input bit exp_sup);
      logic [3:0]  strb;
      logic        blk;
      logic [31:0] exp_rd;
      int          idx;
      bit          done;
      blk    = !tm0 && (addr[1:0] == 2'b01);
      strb   = tm0 ? 4'(1 << addr[1:0]) : size_tbl[addr[1:0]];
      idx    = int'(addr[9:2]);
      exp_rd = ref_mem[idx];
      mem_wait = wclk;
      clear_mon();
      bus_start(addr, wr, tm0, data);
      if (!hit) begin
         repeat (8) @(negedge nub_clkn);
         #1;
         chk("nomatch_valid", 32'(valid_seen), 32'd0);
         chk("nomatch_ack", 32'(ack_count), 32'd0);
      end else begin
         done = 1'b0;
         for (int i = 0; i < 60 && !done; i++) begin
            @(negedge nub_clkn);
            #1;
            if (ack_count > 0 && cyc >= ack_first + 2) done = 1'b1;
         end
         chk("ack_seen", 32'(done), 32'd1);
         chk("ack_len", 32'(ack_count), 32'd1);
         if (blk) begin
            chk("blk_no_valid", 32'(valid_seen), 32'd0);
            chk("blk_status", 32'(stat_seen), 32'd1);
         end else begin
            chk("status", 32'(stat_seen), 32'd0);
            chk("ack_after_ready", 32'(ack_first - ready_cyc), 32'd1);
            chk("valid_in_ack", 32'(valid_in_ack), 32'd0);
            chk("addr", addr_seen, {addr[31:2], 2'b00});
            chk("strobe", 32'(strobe_seen), wr ? 32'(strb) : 32'd0);
            chk("myslot", 32'(myslot_seen), 32'(exp_my));
            chk("super", 32'(super_seen), 32'(exp_sup));
            if (wr) begin
               chk("wdata", wdata_seen, data);
               for (int b = 0; b < 4; b++)
                  if (strb[b]) ref_mem[idx][b*8 +: 8] = data[b*8 +: 8];
            end else begin
               chk("rdata", rdata_seen, exp_rd);
            end
         end
      end
      $display("txn addr=%h wr=%0d tm0=%0d data=%h wait=%0d hit=%0d", addr, wr, tm0, data, wclk, hit);
   endtask

   initial begin
      int kind, widx, wclk;
      logic [1:0]  a10;
      logic        tm0, wr;
      logic [31:0] addr, data;

      for (int i = 0; i < 256; i++) begin
         mem_store[i] = '0;
         ref_mem[i]   = '0;
      end
      clear_mon();

      repeat (3) @(negedge nub_clkn);
      #1;
      chk("rst_valid", 32'(mem_valid), 32'd0);
      chk("rst_write", 32'(mem_write), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_myslot", 32'(mem_myslot), 32'd0);
      chk("rst_super", 32'(mem_super), 32'd0);
      chk("rst_ackn", 32'(nub_ackn), 32'd1);
      @(posedge nub_clkn);
      #10 nub_resetn = 1'b1;

      // Slot 0 directed set
      do_txn(32'hF000_0000, 1'b1, 1'b0, 32'h8765_4321, 0, 1, 1, 0);
      do_txn(32'hF000_0000, 1'b0, 1'b0, 32'h0,         0, 1, 1, 0);
      do_txn(32'hF000_0006, 1'b1, 1'b0, 32'h8765_4321, 1, 1, 1, 0);
      do_txn(32'hF000_000B, 1'b1, 1'b0, 32'h8765_4321, 3, 1, 1, 0);
      do_txn(32'hF000_0004, 1'b0, 1'b0, 32'h0,         1, 1, 1, 0);
      do_txn(32'hF000_0008, 1'b0, 1'b0, 32'h0,         3, 1, 1, 0);
      for (int n = 0; n < 4; n++)
         do_txn(32'hF000_000C + 32'(4*n + n), 1'b1, 1'b1, 32'h8765_4321, n % 2, 1, 1, 0);
      for (int n = 0; n < 4; n++)
         do_txn(32'hF000_000C + 32'(4*n), 1'b0, 1'b0, 32'h0, 3 - n, 1, 1, 0);
      do_txn(32'hF000_0011, 1'b0, 1'b0, 32'h0, 0, 1, 1, 0);
      do_txn(32'hF100_0000, 1'b1, 1'b0, 32'hDEAD_BEEF, 0, 0, 0, 0);
      do_txn(32'hF100_0000, 1'b0, 1'b0, 32'h0,         0, 0, 0, 0);

      // Slot 3: super-slot and standard slot space
      nub_idn = ~4'h3;
      do_txn(32'h3000_0040, 1'b1, 1'b0, 32'hCAFE_F00D, 1, 1, 0, 1);
      do_txn(32'h3000_0040, 1'b0, 1'b0, 32'h0,         0, 1, 0, 1);
      do_txn(32'hF300_0044, 1'b1, 1'b0, 32'h1234_5678, 2, 1, 1, 0);
      do_txn(32'hF300_0044, 1'b0, 1'b0, 32'h0,         0, 1, 1, 0);
      do_txn(32'h4000_0040, 1'b0, 1'b0, 32'h0,         0, 0, 0, 0);
      nub_idn = 4'hF;

      // Randomised single beats in slot 0
      for (int t = 0; t < 40; t++) begin
         kind = int'($urandom_range(0, 4));
         widx = int'($urandom_range(0, 15));
         wclk = int'($urandom_range(0, 3));
         wr   = 1'($urandom_range(0, 1));
         data = $urandom;
         case (kind)
            0:       begin tm0 = 1'b0; a10 = 2'b00; end
            1:       begin tm0 = 1'b0; a10 = 2'($urandom_range(2, 3)); end
            2:       begin tm0 = 1'b0; a10 = 2'b01; end
            default: begin tm0 = 1'b1; a10 = 2'($urandom_range(0, 3)); end
         endcase
         addr = 32'hF000_0100 + 32'(widx * 4) + 32'(a10);
         do_txn(addr, wr, tm0, data, wclk, 1, 1, 0);
      end

      // Reset while stalled in MEM
      mem_wait = 1000;
      clear_mon();
      bus_start(32'hF000_0020, 1'b1, 1'b0, 32'hA5A5_5A5A);
      repeat (3) @(posedge nub_clkn);
      chk("stall_valid", 32'(mem_valid), 32'd1);
      #10 nub_resetn = 1'b0;
      #1;
      chk("midrst_valid", 32'(mem_valid), 32'd0);
      chk("midrst_write", 32'(mem_write), 32'd0);
      chk("midrst_addr", mem_addr, 32'd0);
      chk("midrst_ackn", 32'(nub_ackn), 32'd1);
      repeat (2) @(posedge nub_clkn);
      #10 nub_resetn = 1'b1;
      repeat (3) @(negedge nub_clkn);
      #1;
      chk("midrst_no_ack", 32'(ack_count), 32'd0);
      $display("txn reset-during-MEM addr=f0000020");
      do_txn(32'hF000_0020, 1'b1, 1'b0, 32'h0BAD_F00D, 1, 1, 1, 0);
      do_txn(32'hF000_0020, 1'b0, 1'b0, 32'h0,         2, 1, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
